// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle controller:
// opcodes, ALU fields, FSM states, mux selects, exception codes.
package ctrl_pkg;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam logic [4:0] AF_ADD = 5'b00000;
  localparam logic [4:0] AF_SUB = 5'b00001;
  localparam logic [4:0] AF_MUL = 5'b00110;
  localparam logic [4:0] AF_DIV = 5'b00111;

  typedef enum logic [2:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_MDWAIT,
    S_WB
  } state_e;

  localparam logic [1:0] WS_ALU  = 2'd0;
  localparam logic [1:0] WS_MEM  = 2'd1;
  localparam logic [1:0] WS_MD   = 2'd2;
  localparam logic [1:0] WS_CODE = 2'd3;

  localparam logic [1:0] PS_INC = 2'd0;
  localparam logic [1:0] PS_BR  = 2'd1;
  localparam logic [1:0] PS_JT  = 2'd2;
  localparam logic [1:0] PS_REG = 2'd3;

  localparam logic [31:0] EC_ADD  = 32'd1;
  localparam logic [31:0] EC_ADDI = 32'd2;
  localparam logic [31:0] EC_SUB  = 32'd3;
  localparam logic [31:0] EC_MUL  = 32'd4;
  localparam logic [31:0] EC_DIV  = 32'd5;

  // One-hot instruction class bit positions
  localparam int CL_ADD  = 0;
  localparam int CL_SUB  = 1;
  localparam int CL_RALU = 2;
  localparam int CL_ADDI = 3;
  localparam int CL_MUL  = 4;
  localparam int CL_DIV  = 5;
  localparam int CL_LW   = 6;
  localparam int CL_SW   = 7;
  localparam int CL_BNE  = 8;
  localparam int CL_BLT  = 9;
  localparam int CL_J    = 10;
  localparam int CL_JAL  = 11;
  localparam int CL_JR   = 12;
  localparam int CL_BEX  = 13;
  localparam int CL_SETX = 14;
  localparam int CL_NOP  = 15;
  localparam int NCLS    = 16;

  typedef logic [NCLS-1:0] cls_t;

  // $rstatus code for an excepting class
  function automatic logic [31:0] exc_code(input cls_t c);
    logic [31:0] r;
    r = '0;
    if (c[CL_ADD])  r = EC_ADD;
    if (c[CL_ADDI]) r = EC_ADDI;
    if (c[CL_SUB])  r = EC_SUB;
    if (c[CL_MUL])  r = EC_MUL;
    if (c[CL_DIV])  r = EC_DIV;
    return r;
  endfunction

endpackage

// File: rtl/insn_class_dec.sv
// Opcode / ALU-field decode into a one-hot class vector.
// Anything not in the opcode map decodes as NOP.
module insn_class_dec
  import ctrl_pkg::*;
#(
  parameter int OPW    = 5,
  parameter int ALUOPW = 5
) (
  input  logic [OPW-1:0]    op,
  input  logic [ALUOPW-1:0] fn,
  output cls_t              cls
);

  // Exactly one class bit is set for every encoding
  always_comb begin
    cls = '0;
    unique case (op)
      OPW'(OP_R): begin
        unique case (fn)
          ALUOPW'(AF_ADD): cls[CL_ADD]  = 1'b1;
          ALUOPW'(AF_SUB): cls[CL_SUB]  = 1'b1;
          ALUOPW'(AF_MUL): cls[CL_MUL]  = 1'b1;
          ALUOPW'(AF_DIV): cls[CL_DIV]  = 1'b1;
          default:         cls[CL_RALU] = 1'b1;
        endcase
      end
      OPW'(OP_J):    cls[CL_J]    = 1'b1;
      OPW'(OP_BNE):  cls[CL_BNE]  = 1'b1;
      OPW'(OP_JAL):  cls[CL_JAL]  = 1'b1;
      OPW'(OP_JR):   cls[CL_JR]   = 1'b1;
      OPW'(OP_ADDI): cls[CL_ADDI] = 1'b1;
      OPW'(OP_BLT):  cls[CL_BLT]  = 1'b1;
      OPW'(OP_SW):   cls[CL_SW]   = 1'b1;
      OPW'(OP_LW):   cls[CL_LW]   = 1'b1;
      OPW'(OP_SETX): cls[CL_SETX] = 1'b1;
      OPW'(OP_BEX):  cls[CL_BEX]  = 1'b1;
      default:       cls[CL_NOP]  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with
// mul/div handshake, bounded wait and $rstatus writes.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int IW         = 32,
  parameter int OPW        = 5,
  parameter int ALUOPW     = 5,
  parameter int RSTATUS    = 30,
  parameter int MD_TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IW-1:0]     q_imem,
  input  logic              alu_ovf,
  input  logic              alu_ne,
  input  logic              alu_lt,
  input  logic              md_ready,
  input  logic              md_exception,
  output logic              ir_en,
  output logic              pc_en,
  output logic [1:0]        pc_sel,
  output logic [ALUOPW-1:0] ALUop,
  output logic              ALUinB,
  output logic              wren,
  output logic              ctrl_writeEnable,
  output logic [1:0]        wr_sel,
  output logic [4:0]        wr_reg,
  output logic [31:0]       wr_code,
  output logic              ctrl_MULT,
  output logic              ctrl_DIV,
  output logic              busy,
  output logic              md_timeout
);

  localparam int CW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     ir_q, ir_d;
  cls_t              cls_q, cls_d, cls_dec;
  logic [4:0]        rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              tmo_q, tmo_d;
  logic              exc;

  logic              ir_en_q, ir_en_d;
  logic              pc_en_q, pc_en_d;
  logic [1:0]        pc_sel_q, pc_sel_d;
  logic [ALUOPW-1:0] aluop_q, aluop_d;
  logic              alub_q, alub_d;
  logic              wren_q, wren_d;
  logic              we_q, we_d;
  logic [1:0]        wr_sel_q, wr_sel_d;
  logic [4:0]        wr_reg_q, wr_reg_d;
  logic [31:0]       wr_code_q, wr_code_d;
  logic              mult_q, mult_d;
  logic              div_q, div_d;
  logic              busy_q, busy_d;
  logic              bne_q, bne_d;
  logic              blt_q, blt_d;
  logic              bex_q, bex_d;

  logic [OPW-1:0]    op_f;
  logic [ALUOPW-1:0] fn_f;
  logic [4:0]        rd_f;
  logic [31:0]       t_f;

  assign op_f = ir_q[IW-1 -: OPW];
  assign fn_f = ir_q[ALUOPW+1:2];
  assign rd_f = ir_q[IW-OPW-1 -: 5];
  assign t_f  = 32'(ir_q[IW-OPW-1:0]);

  insn_class_dec #(
    .OPW    (OPW),
    .ALUOPW (ALUOPW)
  ) u_dec (
    .op  (op_f),
    .fn  (fn_f),
    .cls (cls_dec)
  );

  // Next state, IR capture, decode latch and mul/div wait counter
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cls_d   = cls_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    exc     = 1'b0;
    if (ir_en_q) ir_d = q_imem;
    unique case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_EXEC;
        cls_d   = cls_dec;
        rd_d    = rd_f;
      end
      S_EXEC: begin
        unique case (1'b1)
          cls_q[CL_ADD], cls_q[CL_SUB], cls_q[CL_ADDI]: begin
            state_d = S_WB;
            exc     = alu_ovf;
          end
          cls_q[CL_RALU]: state_d = S_WB;
          cls_q[CL_LW], cls_q[CL_SW]: state_d = S_MEM;
          cls_q[CL_MUL], cls_q[CL_DIV]: begin
            state_d = S_MDWAIT;
            cnt_d   = '0;
          end
          cls_q[CL_BNE], cls_q[CL_BLT], cls_q[CL_J],
          cls_q[CL_JAL], cls_q[CL_JR], cls_q[CL_BEX],
          cls_q[CL_SETX], cls_q[CL_NOP]: state_d = S_FETCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: state_d = cls_q[CL_LW] ? S_WB : S_FETCH;
      S_MDWAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (md_ready) begin
          state_d = S_WB;
          exc     = md_exception;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_WB;
          exc     = 1'b1;
          tmo_d   = 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_RST;
    endcase
  end

  // Outputs for the state being entered, from the latched IR
  always_comb begin
    ir_en_d   = 1'b0;
    pc_en_d   = 1'b0;
    pc_sel_d  = PS_INC;
    aluop_d   = '0;
    alub_d    = 1'b0;
    wren_d    = 1'b0;
    we_d      = 1'b0;
    wr_sel_d  = WS_ALU;
    wr_reg_d  = '0;
    wr_code_d = '0;
    mult_d    = 1'b0;
    div_d     = 1'b0;
    bne_d     = 1'b0;
    blt_d     = 1'b0;
    bex_d     = 1'b0;
    busy_d    = (state_d != S_FETCH);
    unique case (state_d)
      S_FETCH: ir_en_d = 1'b1;
      S_EXEC: begin
        unique case (1'b1)
          cls_dec[CL_ADD], cls_dec[CL_SUB],
          cls_dec[CL_RALU]: aluop_d = fn_f;
          cls_dec[CL_ADDI], cls_dec[CL_LW],
          cls_dec[CL_SW]: alub_d = 1'b1;
          cls_dec[CL_BNE]: begin
            aluop_d = ALUOPW'(AF_SUB);
            pc_en_d = 1'b1;
            bne_d   = 1'b1;
          end
          cls_dec[CL_BLT]: begin
            aluop_d = ALUOPW'(AF_SUB);
            pc_en_d = 1'b1;
            blt_d   = 1'b1;
          end
          cls_dec[CL_BEX]: begin
            aluop_d = ALUOPW'(AF_SUB);
            pc_en_d = 1'b1;
            bex_d   = 1'b1;
          end
          cls_dec[CL_J]: begin
            pc_en_d  = 1'b1;
            pc_sel_d = PS_JT;
          end
          cls_dec[CL_JAL]: begin
            pc_en_d  = 1'b1;
            pc_sel_d = PS_JT;
            we_d     = 1'b1;
            wr_sel_d = WS_CODE;
            wr_reg_d = 5'd31;
          end
          cls_dec[CL_JR]: begin
            pc_en_d  = 1'b1;
            pc_sel_d = PS_REG;
          end
          cls_dec[CL_SETX]: begin
            pc_en_d   = 1'b1;
            we_d      = 1'b1;
            wr_sel_d  = WS_CODE;
            wr_reg_d  = 5'(RSTATUS);
            wr_code_d = t_f;
          end
          cls_dec[CL_MUL]: mult_d  = 1'b1;
          cls_dec[CL_DIV]: div_d   = 1'b1;
          cls_dec[CL_NOP]: pc_en_d = 1'b1;
          default: ;
        endcase
      end
      S_MEM: begin
        wren_d  = cls_q[CL_SW];
        pc_en_d = cls_q[CL_SW];
      end
      S_WB: begin
        pc_en_d = 1'b1;
        if (exc) begin
          we_d      = 1'b1;
          wr_reg_d  = 5'(RSTATUS);
          wr_sel_d  = WS_CODE;
          wr_code_d = exc_code(cls_q);
        end else begin
          we_d     = (rd_q != 5'd0);
          wr_reg_d = rd_q;
          if (cls_q[CL_LW])
            wr_sel_d = WS_MEM;
          else if (cls_q[CL_MUL] || cls_q[CL_DIV])
            wr_sel_d = WS_MD;
        end
      end
      default: ;
    endcase
  end

  // State, context and registered outputs; reset drops all
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_RST;
      ir_q      <= '0;
      cls_q     <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      tmo_q     <= 1'b0;
      ir_en_q   <= 1'b0;
      pc_en_q   <= 1'b0;
      pc_sel_q  <= PS_INC;
      aluop_q   <= '0;
      alub_q    <= 1'b0;
      wren_q    <= 1'b0;
      we_q      <= 1'b0;
      wr_sel_q  <= WS_ALU;
      wr_reg_q  <= '0;
      wr_code_q <= '0;
      mult_q    <= 1'b0;
      div_q     <= 1'b0;
      busy_q    <= 1'b0;
      bne_q     <= 1'b0;
      blt_q     <= 1'b0;
      bex_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cls_q     <= cls_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      ir_en_q   <= ir_en_d;
      pc_en_q   <= pc_en_d;
      pc_sel_q  <= pc_sel_d;
      aluop_q   <= aluop_d;
      alub_q    <= alub_d;
      wren_q    <= wren_d;
      we_q      <= we_d;
      wr_sel_q  <= wr_sel_d;
      wr_reg_q  <= wr_reg_d;
      wr_code_q <= wr_code_d;
      mult_q    <= mult_d;
      div_q     <= div_d;
      busy_q    <= busy_d;
      bne_q     <= bne_d;
      blt_q     <= blt_d;
      bex_q     <= bex_d;
    end
  end

  // Branch flags only exist in EXEC, where the ALU flags
  // are valid, so the taken select is resolved late
  always_comb begin
    pc_sel = pc_sel_q;
    if (bne_q) pc_sel = alu_ne ? PS_BR : PS_INC;
    if (blt_q) pc_sel = alu_lt ? PS_BR : PS_INC;
    if (bex_q) pc_sel = alu_ne ? PS_JT : PS_INC;
  end

  assign ir_en            = ir_en_q;
  assign pc_en            = pc_en_q;
  assign ALUop            = aluop_q;
  assign ALUinB           = alub_q;
  assign wren             = wren_q;
  assign ctrl_writeEnable = we_q;
  assign wr_sel           = wr_sel_q;
  assign wr_reg           = wr_reg_q;
  assign wr_code          = wr_code_q;
  assign ctrl_MULT        = mult_q;
  assign ctrl_DIV         = div_q;
  assign busy             = busy_q;
  assign md_timeout       = tmo_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction cycle traces
// from an ISA-level model, random stimulus and resets.
module tb_multicycle_ctrl;

  localparam int TMO = 12;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] q_imem = '0;
  logic        alu_ovf = 1'b0;
  logic        alu_ne = 1'b0;
  logic        alu_lt = 1'b0;
  logic        md_ready = 1'b0;
  logic        md_exception = 1'b0;
  logic        ir_en, pc_en, ALUinB, wren;
  logic        ctrl_writeEnable, ctrl_MULT, ctrl_DIV;
  logic        busy, md_timeout;
  logic [1:0]  pc_sel, wr_sel;
  logic [4:0]  ALUop, wr_reg;
  logic [31:0] wr_code;

  multicycle_ctrl #(
    .IW         (32),
    .OPW        (5),
    .ALUOPW     (5),
    .RSTATUS    (30),
    .MD_TIMEOUT (TMO)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .q_imem           (q_imem),
    .alu_ovf          (alu_ovf),
    .alu_ne           (alu_ne),
    .alu_lt           (alu_lt),
    .md_ready         (md_ready),
    .md_exception     (md_exception),
    .ir_en            (ir_en),
    .pc_en            (pc_en),
    .pc_sel           (pc_sel),
    .ALUop            (ALUop),
    .ALUinB           (ALUinB),
    .wren             (wren),
    .ctrl_writeEnable (ctrl_writeEnable),
    .wr_sel           (wr_sel),
    .wr_reg           (wr_reg),
    .wr_code          (wr_code),
    .ctrl_MULT        (ctrl_MULT),
    .ctrl_DIV         (ctrl_DIV),
    .busy             (busy),
    .md_timeout       (md_timeout)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        ir_en;
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic [4:0]  aluop;
    logic        alub;
    logic        wren;
    logic        we;
    logic [1:0]  wsel;
    logic [4:0]  wreg;
    logic        mult;
    logic        div;
    logic        busy;
    logic        tmo;
    logic [31:0] code;
  } out_t;

  typedef struct {
    logic [31:0] imem;
    logic        ovf, ne, lt, rdy, mexc;
    out_t        o;
  } cyc_t;

  cyc_t q[$];
  int   n_tot = 0;
  int   n_bad = 0;
  int   ins_no = 0;
  bit   tmo_m = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic out_t sample();
    out_t s;
    s.ir_en = ir_en;
    s.pc_en = pc_en;
    s.pc_sel = pc_sel;
    s.aluop = ALUop;
    s.alub = ALUinB;
    s.wren = wren;
    s.we = ctrl_writeEnable;
    s.wsel = wr_sel;
    s.wreg = wr_reg;
    s.mult = ctrl_MULT;
    s.div = ctrl_DIV;
    s.busy = busy;
    s.tmo = md_timeout;
    s.code = wr_code;
    return s;
  endfunction

  // A busy cycle with nothing asserted and junk inputs
  function automatic cyc_t blank();
    cyc_t c;
    c.imem = $urandom;
    c.ovf = 1'($urandom_range(0, 1));
    c.ne = 1'($urandom_range(0, 1));
    c.lt = 1'($urandom_range(0, 1));
    c.rdy = 1'($urandom_range(0, 1));
    c.mexc = 1'($urandom_range(0, 1));
    c.o = '0;
    c.o.busy = 1'b1;
    c.o.tmo = tmo_m;
    return c;
  endfunction

  // ISA-level trace: one record per cycle, FETCH to last
  task automatic gen(input logic [31:0] ir,
                     input bit ovf, input bit ne,
                     input bit lt, input int wn,
                     input bit mexc);
    logic [4:0] op, fn, rd;
    logic [31:0] t, code;
    bit is_r, ismd, exc;
    int n;
    cyc_t c, w;
    op = ir[31:27];
    fn = ir[6:2];
    rd = ir[26:22];
    t = {5'b0, ir[26:0]};
    is_r = (op == 5'd0);
    ismd = is_r && (fn == 5'd6 || fn == 5'd7);
    c = blank();
    c.imem = ir;
    c.o.ir_en = 1'b1;
    c.o.busy = 1'b0;
    q.push_back(c);
    q.push_back(blank());
    c = blank();
    c.ovf = ovf;
    c.ne = ne;
    c.lt = lt;
    if ((is_r && !ismd) || op == 5'd5) begin
      c.o.aluop = is_r ? fn : 5'd0;
      c.o.alub = !is_r;
      q.push_back(c);
      code = 0;
      if (op == 5'd5) code = 2;
      else if (fn == 5'd0) code = 1;
      else if (fn == 5'd1) code = 3;
      w = blank();
      w.o.pc_en = 1'b1;
      if (ovf && code != 0) begin
        w.o.we = 1'b1;
        w.o.wreg = 5'd30;
        w.o.wsel = 2'd3;
        w.o.code = code;
      end else begin
        w.o.we = (rd != 0);
        w.o.wreg = rd;
      end
      q.push_back(w);
    end else if (op == 5'd7 || op == 5'd8) begin
      c.o.alub = 1'b1;
      q.push_back(c);
      w = blank();
      w.o.wren = (op == 5'd7);
      w.o.pc_en = (op == 5'd7);
      q.push_back(w);
      if (op == 5'd8) begin
        w = blank();
        w.o.pc_en = 1'b1;
        w.o.we = (rd != 0);
        w.o.wreg = rd;
        w.o.wsel = 2'd1;
        q.push_back(w);
      end
    end else if (ismd) begin
      c.o.mult = (fn == 5'd6);
      c.o.div = (fn == 5'd7);
      q.push_back(c);
      n = (wn > TMO) ? TMO : wn;
      for (int i = 0; i < n; i++) begin
        w = blank();
        w.rdy = (i == wn - 1);
        if (w.rdy) w.mexc = mexc;
        q.push_back(w);
      end
      exc = (wn > TMO) || mexc;
      if (wn > TMO) tmo_m = 1;
      w = blank();
      w.o.pc_en = 1'b1;
      if (exc) begin
        w.o.we = 1'b1;
        w.o.wreg = 5'd30;
        w.o.wsel = 2'd3;
        w.o.code = (fn == 5'd6) ? 32'd4 : 32'd5;
      end else begin
        w.o.we = (rd != 0);
        w.o.wreg = rd;
        w.o.wsel = 2'd2;
      end
      q.push_back(w);
    end else begin
      c.o.pc_en = 1'b1;
      case (op)
        5'd2: begin
          c.o.aluop = 5'd1;
          c.o.pc_sel = ne ? 2'd1 : 2'd0;
        end
        5'd6: begin
          c.o.aluop = 5'd1;
          c.o.pc_sel = lt ? 2'd1 : 2'd0;
        end
        5'd22: begin
          c.o.aluop = 5'd1;
          c.o.pc_sel = ne ? 2'd2 : 2'd0;
        end
        5'd1: c.o.pc_sel = 2'd2;
        5'd3: begin
          c.o.pc_sel = 2'd2;
          c.o.we = 1'b1;
          c.o.wsel = 2'd3;
          c.o.wreg = 5'd31;
        end
        5'd4: c.o.pc_sel = 2'd3;
        5'd21: begin
          c.o.we = 1'b1;
          c.o.wsel = 2'd3;
          c.o.wreg = 5'd30;
          c.o.code = t;
        end
        default: ;
      endcase
      q.push_back(c);
    end
  endtask

  // Play the queued trace; optionally reset at one cycle
  task automatic run(input int abort_at);
    int i;
    cyc_t c;
    i = 0;
    while (q.size() != 0) begin
      c = q.pop_front();
      @(posedge clock);
      #1;
      q_imem = c.imem;
      alu_ovf = c.ovf;
      alu_ne = c.ne;
      alu_lt = c.lt;
      md_ready = c.rdy;
      md_exception = c.mexc;
      #1;
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        chk($sformatf("i%0d rst_async", ins_no),
            64'(sample()), 64'd0);
        q.delete();
        tmo_m = 0;
        @(posedge clock);
        #1;
        chk($sformatf("i%0d rst_hold", ins_no),
            64'(sample()), 64'd0);
        #1 reset = 1'b0;
      end else begin
        chk($sformatf("i%0d cyc%0d", ins_no, i),
            64'(sample()), 64'(c.o));
        i++;
      end
    end
    ins_no++;
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] fn,
                                        input logic [4:0] rd);
    return {5'd0, rd, 5'd1, 5'd2, 5'd0, fn, 2'b00};
  endfunction

  function automatic logic [31:0] o_ins(input logic [4:0] op,
                                        input logic [4:0] rd);
    return {op, rd, 5'd1, 17'h00abc};
  endfunction

  initial begin
    logic [31:0] r, ir;
    logic [4:0] rd, fn;
    int k, wn, ab;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_state", 64'(sample()), 64'd0);
    #1 reset = 1'b0;

    gen(r_ins(5'd0, 5'd3), 0, 0, 0, 0, 0);
    run(-1);
    gen(o_ins(5'd5, 5'd5), 1, 0, 0, 0, 0);
    run(-1);
    gen(r_ins(5'd6, 5'd7), 0, 0, 0, 10, 0);
    run(-1);
    gen(r_ins(5'd7, 5'd9), 0, 0, 0, 3, 1);
    run(-1);
    gen(r_ins(5'd7, 5'd9), 0, 0, 0, TMO + 5, 0);
    run(-1);
    gen(r_ins(5'd1, 5'd4), 0, 0, 0, 0, 0);
    run(-1);
    gen(o_ins(5'd2, 5'd1), 0, 1, 0, 0, 0);
    run(-1);
    gen(o_ins(5'd2, 5'd1), 0, 0, 1, 0, 0);
    run(-1);
    gen(o_ins(5'd6, 5'd1), 0, 0, 1, 0, 0);
    run(-1);
    gen({5'd3, 27'd100}, 0, 0, 0, 0, 0);
    run(-1);
    gen({5'd21, 27'h4321}, 0, 0, 0, 0, 0);
    run(-1);
    gen({5'd22, 27'd77}, 0, 1, 0, 0, 0);
    run(-1);
    gen(o_ins(5'd8, 5'd6), 0, 0, 0, 0, 0);
    run(-1);
    gen(o_ins(5'd7, 5'd6), 0, 0, 0, 0, 0);
    run(-1);
    gen(r_ins(5'd6, 5'd2), 0, 0, 0, TMO + 3, 0);
    run(7);
    gen(r_ins(5'd0, 5'd0), 1, 0, 0, 0, 0);
    run(-1);

    for (int n = 0; n < 300; n++) begin
      r = $urandom;
      rd = (($urandom % 4) == 0) ? 5'd0 : r[26:22];
      k = $urandom_range(0, 15);
      fn = 5'd0;
      case (k)
        0: fn = 5'd0;
        1: fn = 5'd1;
        2: fn = 5'd6;
        3: fn = 5'd7;
        4: fn = 5'($urandom_range(2, 5));
        default: ;
      endcase
      ir = {5'd0, rd, r[21:0]};
      if (k <= 4) ir[6:2] = fn;
      case (k)
        5:  ir[31:27] = 5'd5;
        6:  ir[31:27] = 5'd8;
        7:  ir[31:27] = 5'd7;
        8:  ir[31:27] = 5'd2;
        9:  ir[31:27] = 5'd6;
        10: ir[31:27] = 5'd1;
        11: ir[31:27] = 5'd3;
        12: ir[31:27] = 5'd4;
        13: ir[31:27] = 5'd22;
        14: ir[31:27] = 5'd21;
        15: ir[31:27] = 5'($urandom_range(9, 20));
        default: ;
      endcase
      wn = $urandom_range(1, TMO + 2);
      gen(ir, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), wn,
          1'($urandom_range(0, 1)));
      ab = -1;
      if (($urandom % 20) == 0)
        ab = $urandom_range(0, q.size() - 1);
      run(ab);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
